// File: rtl/multdiv_bus_reader_if.sv
// ============================================================================
// Module   : multdiv_bus_reader_if
// Purpose  : Request/result bundle between the multdiv control FSM, the result
//            bus sources and the bus reader.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface multdiv_bus_reader_if #(
   parameter int NUM_SRC = 2,
   parameter int SEL_W   = 1
);
   logic                 req;
   logic [SEL_W-1:0]     src_sel;
   logic                 is_div;
   logic                 div_zero;
   // Shared result bus; a source drives it only while its out_en bit is high.
   logic [63:0]          bus;
   logic [NUM_SRC-1:0]   out_en;
   logic                 busy;
   logic                 done;
   logic [31:0]          result;
   logic [31:0]          result_hi;
   logic                 exception;
   logic [NUM_SRC-1:0]   src_clr;

   modport master (
      output req, src_sel, is_div, div_zero, bus,
      input  out_en, busy, done, result, result_hi, exception, src_clr
   );

   modport slave (
      input  req, src_sel, is_div, div_zero, bus,
      output out_en, busy, done, result, result_hi, exception, src_clr
   );
endinterface

`default_nettype wire

// File: rtl/multdiv_bus_reader.sv
// ============================================================================
// Module   : multdiv_bus_reader
// Purpose  : Enables one result-bus source, waits SETTLE cycles, captures the
//            64-bit bus and returns result, upper word and exception flag.
//            Optional macro MULTDIV_RD_CLR_EN enables the src_clr pulse.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multdiv_bus_reader #(
   parameter int NUM_SRC = 2,
   parameter int SEL_W   = 1,
   parameter int SETTLE  = 1
) (
   input  logic                  clk,
   input  logic                  clr,
   multdiv_bus_reader_if.slave   rd
);

   localparam int                CNT_W      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0]  SETTLE_M1  = CNT_W'(SETTLE - 1);
   localparam logic [SEL_W:0]    NUM_SRC_L  = (SEL_W + 1)'(NUM_SRC);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DRIVE   = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic                 valid_q, valid_d;
   logic                 is_div_q, is_div_d;
   logic                 div_zero_q, div_zero_d;
   logic [NUM_SRC-1:0]   out_en_q, out_en_d;
   logic [31:0]          result_q, result_d;
   logic [31:0]          result_hi_q, result_hi_d;
   logic                 exc_q, exc_d;
   logic [NUM_SRC-1:0]   w_onehot;
   logic                 w_sel_ok;

   assign w_sel_ok = ({1'b0, rd.src_sel} < NUM_SRC_L);

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         sel_q       <= '0;
         valid_q     <= 1'b0;
         is_div_q    <= 1'b0;
         div_zero_q  <= 1'b0;
         out_en_q    <= '0;
         result_q    <= '0;
         result_hi_q <= '0;
         exc_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         valid_q     <= valid_d;
         is_div_q    <= is_div_d;
         div_zero_q  <= div_zero_d;
         out_en_q    <= out_en_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         exc_q       <= exc_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sel_d       = sel_q;
      valid_d     = valid_q;
      is_div_d    = is_div_q;
      div_zero_d  = div_zero_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      exc_d       = exc_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (rd.req) begin
               state_d    = S_DRIVE;
               cnt_d      = SETTLE_M1;
               sel_d      = rd.src_sel;
               valid_d    = w_sel_ok;
               is_div_d   = rd.is_div;
               div_zero_d = rd.div_zero;
            end
         end
         S_DRIVE: begin
            if (cnt_q == '0) begin
               state_d = S_CAPTURE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_CAPTURE: begin
            state_d = S_DONE;
            if (valid_q) begin
               result_d    = rd.bus[31:0];
               result_hi_d = rd.bus[63:32];
               // Multiply: the 64-bit product must be the sign extension of its low word.
               exc_d       = is_div_q ? div_zero_q
                                      : (rd.bus[63:32] != {32{rd.bus[31]}});
            end else begin
               result_d    = '0;
               result_hi_d = '0;
               exc_d       = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Drive enable follows the next state so it is a clean register output.
   always_comb begin
      w_onehot = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         w_onehot[i] = (sel_d == SEL_W'(i));
      end
      out_en_d = '0;
      if (((state_d == S_DRIVE) || (state_d == S_CAPTURE)) && valid_d) begin
         out_en_d = w_onehot;
      end
   end

   assign rd.out_en    = out_en_q;
   assign rd.busy      = (state_q == S_DRIVE) || (state_q == S_CAPTURE);
   assign rd.done      = (state_q == S_DONE);
   assign rd.result    = result_q;
   assign rd.result_hi = result_hi_q;
   assign rd.exception = exc_q;

`ifdef MULTDIV_RD_CLR_EN
   logic [NUM_SRC-1:0] src_clr_q;

   // out_en during CAPTURE is exactly the consumed source (zero for a bad select).
   always_ff @(posedge clk) begin
      if (clr) begin
         src_clr_q <= '0;
      end else if (state_q == S_CAPTURE) begin
         src_clr_q <= out_en_q;
      end else begin
         src_clr_q <= '0;
      end
   end

   assign rd.src_clr = src_clr_q;
`else
   assign rd.src_clr = '0;
`endif

   a_out_en_onehot0 : assert property (@(posedge clk) disable iff (clr) $onehot0(rd.out_en));
   a_out_en_idle    : assert property (@(posedge clk) disable iff (clr)
                                       (!rd.busy) |-> (rd.out_en == '0));

endmodule

`default_nettype wire

// File: tb/tb_multdiv_bus_reader.sv
// ============================================================================
// Module   : tb_multdiv_bus_reader
// Purpose  : Directed bench for multdiv_bus_reader: a 2-source and a 3-source
//            instance, each checked every cycle against a timeline model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multdiv_bus_reader;

   localparam int NI = 2;
   localparam int ST = 1;

   logic        clk = 1'b0;
   logic        clr;
   logic        chk_on = 1'b0;
   logic        req   [NI];
   logic [1:0]  sel   [NI];
   logic        isdiv [NI];
   logic        dz    [NI];
   logic [63:0] sval  [NI][3];

   logic [2:0]  obs_oe   [NI];
   logic [2:0]  obs_clr  [NI];
   logic        obs_busy [NI];
   logic        obs_done [NI];
   logic [31:0] obs_res  [NI];
   logic [31:0] obs_hi   [NI];
   logic        obs_exc  [NI];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int NS = (g == 0) ? 2 : 3;
      localparam int SW = (g == 0) ? 1 : 2;

      multdiv_bus_reader_if #(.NUM_SRC(NS), .SEL_W(SW)) ifc ();

      multdiv_bus_reader #(.NUM_SRC(NS), .SEL_W(SW), .SETTLE(ST)) u_dut (
         .clk (clk),
         .clr (clr),
         .rd  (ifc.slave)
      );

      logic [63:0] w_bus;
      always_comb begin
         w_bus = '0;
         for (int i = 0; i < NS; i++) begin
            if (ifc.out_en[i]) w_bus = w_bus | sval[g][i];
         end
      end

      assign ifc.bus      = w_bus;
      assign ifc.req      = req[g];
      assign ifc.src_sel  = sel[g][SW-1:0];
      assign ifc.is_div   = isdiv[g];
      assign ifc.div_zero = dz[g];

      assign obs_oe[g]   = 3'(ifc.out_en);
      assign obs_clr[g]  = 3'(ifc.src_clr);
      assign obs_busy[g] = ifc.busy;
      assign obs_done[g] = ifc.done;
      assign obs_res[g]  = ifc.result;
      assign obs_hi[g]   = ifc.result_hi;
      assign obs_exc[g]  = ifc.exception;

      // Model: t counts cycles since the accepting edge; 0 means no read in flight.
      int          t    = 0;
      int          msel = 0;
      logic        mdiv = 1'b0;
      logic        mdz  = 1'b0;
      logic [31:0] mres = '0;
      logic [31:0] mhi  = '0;
      logic        mexc = 1'b0;

      always @(posedge clk) begin
         if (clr) begin
            t = 0; mres = '0; mhi = '0; mexc = 1'b0;
         end else if (t == 0 || t == ST + 2) begin
            if (req[g]) begin
               t = 1; msel = int'(sel[g]); mdiv = isdiv[g]; mdz = dz[g];
            end else begin
               t = 0;
            end
         end else begin
            if (t == ST + 1) begin
               if (msel >= NS) begin
                  mres = '0; mhi = '0; mexc = 1'b1;
               end else begin
                  mres = sval[g][msel][31:0];
                  mhi  = sval[g][msel][63:32];
                  if (mdiv) mexc = mdz;
                  else      mexc = ($signed({mhi, mres}) > 64'sh7FFF_FFFF) ||
                                   ($signed({mhi, mres}) < -64'sh8000_0000);
               end
            end
            t++;
         end
      end

      always @(negedge clk) begin
         if (chk_on) begin
            logic       e_busy, e_done;
            logic [2:0] e_oe, e_clr;
            e_busy = (t >= 1) && (t <= ST + 1);
            e_done = (t == ST + 2);
            e_oe   = (e_busy && msel < NS) ? 3'(1 << msel) : 3'b000;
`ifdef MULTDIV_RD_CLR_EN
            e_clr  = (e_done && msel < NS) ? 3'(1 << msel) : 3'b000;
`else
            e_clr  = 3'b000;
`endif
            chk($sformatf("u%0d.out_en", g),    64'(obs_oe[g]),   64'(e_oe));
            chk($sformatf("u%0d.busy", g),      64'(obs_busy[g]), 64'(e_busy));
            chk($sformatf("u%0d.done", g),      64'(obs_done[g]), 64'(e_done));
            chk($sformatf("u%0d.result", g),    64'(obs_res[g]),  64'(mres));
            chk($sformatf("u%0d.result_hi", g), 64'(obs_hi[g]),   64'(mhi));
            chk($sformatf("u%0d.exception", g), 64'(obs_exc[g]),  64'(mexc));
            chk($sformatf("u%0d.src_clr", g),   64'(obs_clr[g]),  64'(e_clr));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int g, input logic [1:0] s, input logic d, input logic z);
      req[g] = 1'b1; sel[g] = s; isdiv[g] = d; dz[g] = z;
      tick();
      req[g] = 1'b0;
   endtask

   task automatic wait_done(input int g);
      int k = 0;
      while (!obs_done[g] && k < 10) begin
         tick();
         k++;
      end
      chk("wait_done", 64'(obs_done[g]), 64'd1);
   endtask

   initial begin
      clr = 1'b1;
      for (int g = 0; g < NI; g++) begin
         req[g] = 1'b0; sel[g] = 2'd0; isdiv[g] = 1'b0; dz[g] = 1'b0;
         for (int i = 0; i < 3; i++) sval[g][i] = 64'h0;
      end
      tick();
      chk_on = 1'b1;
      tick();
      chk("rst.out_en", 64'(obs_oe[0]),   64'd0);
      chk("rst.busy",   64'(obs_busy[0]), 64'd0);
      chk("rst.result", 64'(obs_res[0]),  64'd0);
      clr = 1'b0;
      tick();

      // T1: latency and out_en window
      sval[0][0] = 64'h0000_0000_0000_002A;
      start(0, 2'd0, 1'b0, 1'b0);
      chk("t1.c1.out_en", 64'(obs_oe[0]), 64'b01);
      tick();
      chk("t1.c2.out_en", 64'(obs_oe[0]), 64'b01);
      tick();
      chk("t1.c3.done",   64'(obs_done[0]), 64'd1);
      chk("t1.result",    64'(obs_res[0]),  64'd42);
      chk("t1.exception", 64'(obs_exc[0]),  64'd0);
      chk("t1.c3.out_en", 64'(obs_oe[0]),   64'd0);
`ifdef MULTDIV_RD_CLR_EN
      chk("t1.src_clr",   64'(obs_clr[0]),  64'b01);
`endif
      tick();
      chk("t1.c4.done",   64'(obs_done[0]), 64'd0);

      // T2: product overflow
      sval[0][0] = 64'h0000_0001_0000_0000;
      start(0, 2'd0, 1'b0, 1'b0);
      wait_done(0);
      chk("t2.result",    64'(obs_res[0]), 64'd0);
      chk("t2.result_hi", 64'(obs_hi[0]),  64'd1);
      chk("t2.exception", 64'(obs_exc[0]), 64'd1);
      tick();

      // T3: negative product, then back-to-back read accepted in DONE
      sval[0][1] = 64'hFFFF_FFFF_FFFF_FFFE;
      start(0, 2'd1, 1'b0, 1'b0);
      wait_done(0);
      chk("t3.result",    64'(obs_res[0]), 64'hFFFF_FFFE);
      chk("t3.exception", 64'(obs_exc[0]), 64'd0);
      sval[0][1] = 64'h0000_0000_7FFF_FFFF;
      start(0, 2'd1, 1'b0, 1'b0);
      chk("t3.b2b.c1.done",   64'(obs_done[0]), 64'd0);
      chk("t3.b2b.c1.out_en", 64'(obs_oe[0]),   64'b10);
      tick();
      chk("t3.b2b.c2.done",   64'(obs_done[0]), 64'd0);
      tick();
      chk("t3.b2b.c3.done",   64'(obs_done[0]), 64'd1);
      chk("t3.b2b.result",    64'(obs_res[0]),  64'h7FFF_FFFF);
      chk("t3.b2b.exception", 64'(obs_exc[0]),  64'd0);
      tick();

      // T4: divide with div_zero; inputs changed and req held after acceptance
      sval[0][1] = 64'h0000_0000_0000_0007;
      start(0, 2'd1, 1'b1, 1'b1);
      chk("t4.out_en", 64'(obs_oe[0]), 64'b10);
      req[0] = 1'b1; sel[0] = 2'd0; dz[0] = 1'b0;
      tick();
      req[0] = 1'b0;
      tick();
      chk("t4.done",      64'(obs_done[0]), 64'd1);
      chk("t4.exception", 64'(obs_exc[0]),  64'd1);
      chk("t4.result",    64'(obs_res[0]),  64'd7);
      tick();
      start(0, 2'd1, 1'b1, 1'b0);
      wait_done(0);
      chk("t4.nodz.exception", 64'(obs_exc[0]), 64'd0);
      tick();

      // T5: 3-source instance, valid read then invalid select
      sval[1][2] = 64'hFFFF_FFFF_8000_0000;
      start(1, 2'd2, 1'b0, 1'b0);
      chk("t5.valid.out_en", 64'(obs_oe[1]), 64'b100);
      wait_done(1);
      chk("t5.valid.exception", 64'(obs_exc[1]), 64'd0);
      tick();
      start(1, 2'd3, 1'b0, 1'b0);
      chk("t5.c1.out_en", 64'(obs_oe[1]),   64'b000);
      chk("t5.c1.busy",   64'(obs_busy[1]), 64'd1);
      tick();
      chk("t5.c2.out_en", 64'(obs_oe[1]),   64'b000);
      tick();
      chk("t5.c3.done",      64'(obs_done[1]), 64'd1);
      chk("t5.result",       64'(obs_res[1]),  64'd0);
      chk("t5.result_hi",    64'(obs_hi[1]),   64'd0);
      chk("t5.exception",    64'(obs_exc[1]),  64'd1);
      chk("t5.src_clr",      64'(obs_clr[1]),  64'd0);
      tick();

      // T6: reset during DRIVE aborts the read
      start(0, 2'd0, 1'b0, 1'b0);
      clr = 1'b1;
      tick();
      chk("t6.out_en", 64'(obs_oe[0]),   64'd0);
      chk("t6.busy",   64'(obs_busy[0]), 64'd0);
      chk("t6.result", 64'(obs_res[0]),  64'd0);
      clr = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t6.no_done", 64'(obs_done[0]), 64'd0);
      end

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
